// File: rtl/sched_pkg.sv
// ============================================================================
// Module   : sched_pkg
// Purpose  : Shared types and helpers for the tick scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sched_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } sched_state_t;

   localparam int OVR_W = 8;

   function automatic int calc_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// Module   : tick_gen
// Purpose  : Prescaler producing a one-cycle tick strobe every DIV clocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
   parameter int DIV = 27000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] c_last = CW'(DIV - 1);
   localparam logic [CW-1:0] c_pre  = CW'(DIV - 2);

   logic [CW-1:0] r_cnt;
   logic          r_tick;

   generate
      if (DIV < 2) begin : g_div_check
         $error("tick_gen: DIV must be at least 2");
      end
   endgenerate

   // Tick is registered one count early so it lines up with count == DIV-1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (!enable) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= (r_cnt == c_pre);
         r_cnt  <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
      end
   end

   assign tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/tick_scheduler.sv
// ============================================================================
// Module   : tick_scheduler
// Purpose  : Round-robin grant of a shared tick timebase to N_REQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_scheduler
   import sched_pkg::*;
#(
   parameter int CLK_HZ  = 27_000_000,
   parameter int TICK_HZ = 1_000,
   parameter int N_REQ   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ-1:0]         done,
   output logic                     tick,
   output logic [N_REQ-1:0]         grant,
   output logic [$clog2(N_REQ)-1:0] grant_idx,
   output logic                     busy,
   output logic [OVR_W-1:0]         overrun_cnt
);

   localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
   localparam int IW  = $clog2(N_REQ);
   localparam logic [IW-1:0]    c_ptr_rst = IW'(N_REQ - 1);
   localparam logic [N_REQ-1:0] c_one     = {{(N_REQ-1){1'b0}}, 1'b1};

   generate
      if ((CLK_HZ % TICK_HZ) != 0) begin : g_div_exact_check
         $error("tick_scheduler: CLK_HZ must be a multiple of TICK_HZ");
      end
      if (N_REQ < 2 || N_REQ > 8) begin : g_nreq_check
         $error("tick_scheduler: N_REQ must be in 2..8");
      end
   endgenerate

   sched_state_t     r_state;
   logic [N_REQ-1:0] r_grant;
   logic [IW-1:0]    r_idx;
   logic [IW-1:0]    r_ptr;
   logic             r_busy;
   logic [OVR_W-1:0] r_ovr;
   logic             w_tick;
   logic [IW-1:0]    w_sel;

   // Descending scan so the smallest offset from ptr+1 is the last to win.
   function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IW-1:0]    p);
      logic [IW-1:0] sel;
      int            k;
      sel = p;
      for (int i = N_REQ; i >= 1; i--) begin
         k = (int'(p) + i) % N_REQ;
         if (r[k]) sel = IW'(k);
      end
      return sel;
   endfunction

   tick_gen #(
      .DIV    (DIV)
   ) u_tick_gen (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .tick   (w_tick)
   );

   assign w_sel = rr_pick(req, r_ptr);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_idx   <= '0;
         r_ptr   <= c_ptr_rst;
         r_busy  <= 1'b0;
         r_ovr   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_tick && (|req)) begin
                  r_grant <= c_one << w_sel;
                  r_idx   <= w_sel;
                  r_busy  <= 1'b1;
                  r_state <= GRANT;
               end
            end
            GRANT: begin
               // A release in the same cycle as a tick swallows that tick.
               if (done[r_idx]) begin
                  r_grant <= '0;
                  r_busy  <= 1'b0;
                  r_ptr   <= r_idx;
                  r_state <= IDLE;
               end else if (w_tick && (r_ovr != {OVR_W{1'b1}})) begin
                  r_ovr <= r_ovr + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign tick        = w_tick;
   assign grant       = r_grant;
   assign grant_idx   = r_idx;
   assign busy        = r_busy;
   assign overrun_cnt = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_tick_scheduler.sv
// ============================================================================
// Module   : tb_tick_scheduler
// Purpose  : Directed self-checking bench for tick_scheduler (DIV=10, N_REQ=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tick_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [3:0] req;
   logic [3:0] done;
   logic       tick;
   logic [3:0] grant;
   logic [1:0] grant_idx;
   logic       busy;
   logic [7:0] overrun_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int n;
   logic [1:0] exp_idx [3];

   tick_scheduler #(
      .CLK_HZ      (10),
      .TICK_HZ     (1),
      .N_REQ       (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .req         (req),
      .done        (done),
      .tick        (tick),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .busy        (busy),
      .overrun_cnt (overrun_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Steps until tick is seen at a negedge; returns number of steps taken.
   task automatic wait_tick(input int max, output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (!tick && cnt < max);
      if (!tick) check("tick_timeout", 32'(tick), 32'd1);
   endtask

   task automatic pulse_done(input logic [3:0] d);
      done = d;
      step();
      done = 4'b0000;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; enable = 1'b1; req = 4'b0000; done = 4'b0000;
      @(negedge clk); @(negedge clk);
      check("rst_tick",  32'(tick),        32'd0);
      check("rst_grant", 32'(grant),       32'd0);
      check("rst_idx",   32'(grant_idx),   32'd0);
      check("rst_busy",  32'(busy),        32'd0);
      check("rst_ovr",   32'(overrun_cnt), 32'd0);
      rst = 1'b1;

      // Free run: ticks at cycles 9, 19, 29 after release.
      for (int cyc = 1; cyc <= 30; cyc++) begin
         step();
         check($sformatf("free_tick_c%0d", cyc), 32'(tick), (cyc % 10 == 9) ? 32'd1 : 32'd0);
      end
      check("free_grant", 32'(grant), 32'd0);
      check("free_ovr",   32'(overrun_cnt), 32'd0);

      // Round-robin over all four requesters.
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_tick(20, n);
         check($sformatf("rr_pre_grant%0d", k), 32'(grant), 32'd0);
         step();
         check($sformatf("rr_grant%0d", k), 32'(grant), 32'(4'b0001 << (k % 4)));
         check($sformatf("rr_busy%0d", k),  32'(busy),  32'd1);
         step();
         pulse_done(grant);
         check($sformatf("rr_rel%0d", k), 32'(grant), 32'd0);
         check($sformatf("rr_relbusy%0d", k), 32'(busy), 32'd0);
      end

      // Sparse requests: pointer is at 0, so 1, 3, 1.
      req = 4'b1010;
      exp_idx[0] = 2'd1; exp_idx[1] = 2'd3; exp_idx[2] = 2'd1;
      for (int k = 0; k < 3; k++) begin
         wait_tick(20, n);
         step();
         check($sformatf("sp_idx%0d", k), 32'(grant_idx), 32'(exp_idx[k]));
         check($sformatf("sp_grant%0d", k), 32'(grant), 32'(4'b0001 << exp_idx[k]));
         step();
         pulse_done(grant);
      end

      // Overrun: hold idx 0 for 35 cycles, with req dropped meanwhile.
      req = 4'b0001;
      wait_tick(20, n);
      step();
      check("ov_grant", 32'(grant), 32'b0001);
      req = 4'b0000;
      for (int c = 0; c < 35; c++) step();
      check("ov_cnt",   32'(overrun_cnt), 32'd3);
      check("ov_hold",  32'(grant), 32'b0001);
      pulse_done(4'b0001);
      check("ov_rel_busy",  32'(busy),  32'd0);
      check("ov_rel_grant", 32'(grant), 32'd0);

      // Tick/done collision.
      req = 4'b0001;
      wait_tick(20, n);
      step();
      check("col_grant", 32'(grant), 32'b0001);
      wait_tick(20, n);
      pulse_done(4'b0001);
      check("col_rel",  32'(grant), 32'd0);
      check("col_busy", 32'(busy),  32'd0);
      check("col_ovr",  32'(overrun_cnt), 32'd3);
      for (int c = 0; c < 9; c++) step();
      check("col_gap_grant", 32'(grant), 32'd0);
      check("col_next_tick", 32'(tick),  32'd1);
      step();
      check("col_regrant", 32'(grant), 32'b0001);

      // Done on non-granted indices must be ignored.
      pulse_done(4'b1110);
      check("ng_grant", 32'(grant), 32'b0001);
      check("ng_busy",  32'(busy),  32'd1);
      pulse_done(4'b0001);
      check("ng_rel", 32'(grant), 32'd0);

      // Saturation: a long grant accumulates over 255 lost ticks.
      wait_tick(20, n);
      step();
      for (int c = 0; c < 2600; c++) step();
      check("sat_ovr", 32'(overrun_cnt), 32'd255);
      pulse_done(4'b0001);
      check("sat_busy", 32'(busy), 32'd0);

      // Asynchronous reset mid-grant.
      wait_tick(20, n);
      step();
      check("ar_pre_grant", 32'(grant), 32'b0001);
      rst = 1'b0;
      #1;
      check("ar_grant", 32'(grant),       32'd0);
      check("ar_busy",  32'(busy),        32'd0);
      check("ar_ovr",   32'(overrun_cnt), 32'd0);
      check("ar_idx",   32'(grant_idx),   32'd0);
      @(negedge clk);
      req = 4'b1111;
      rst = 1'b1;
      wait_tick(20, n);
      check("ar_first_tick_cycles", 32'(n), 32'd9);
      step();
      check("ar_ptr_grant", 32'(grant), 32'b0001);
      pulse_done(4'b0001);

      // Enable low for 7 cycles, then first tick 10 cycles into re-enable.
      req = 4'b0000;
      wait_tick(20, n);
      step();
      enable = 1'b0;
      for (int c = 0; c < 7; c++) begin
         step();
         check($sformatf("en_off_tick%0d", c), 32'(tick), 32'd0);
      end
      enable = 1'b1;
      wait_tick(30, n);
      check("en_first_tick", 32'(n + 1), 32'd10);
      wait_tick(30, n);
      check("en_period", 32'(n), 32'd10);
      check("en_grant",  32'(grant), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/tick_scheduler.md
# tick_scheduler

Time-slot scheduler that shares one 1 kHz timebase between up to N_REQ peripheral requesters (operand keypad scan, 7-segment digit multiplexer, result-display refresh, Booth start debounce). An internal prescaler divides the 27 MHz system clock into a single-cycle tick strobe; no derived clock is generated. On each tick, a round-robin arbiter grants the timebase to one requesting peripheral. The grant is held until that peripheral signals done. The block sits between the top level and the I/O helpers, so every slow activity runs in the main clock domain.

## Interface
- CLK_HZ, 27_000_000, system clock frequency
- TICK_HZ, 1_000, tick rate; DIV = CLK_HZ/TICK_HZ (27000), elaborated as a constant
- N_REQ, 4, number of requesters (2..8)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  prescaler run; low freezes tick generation
- req  in  N_REQ  per-requester service request, level
- done  in  N_REQ  per-requester completion, single-cycle pulse
- tick  out  1  one-cycle strobe every DIV cycles while enabled
- grant  out  N_REQ  one-hot grant, held until matching done
- grant_idx  out  $clog2(N_REQ)  index of current or last grant
- busy  out  1  high while a grant is outstanding
- overrun_cnt  out  8  saturating count of ticks lost while busy

## Operation
- Reset values: tick=0, grant=0, grant_idx=0, busy=0, overrun_cnt=0, prescaler=0, round-robin pointer=N_REQ-1, so the first search starts at index 0.
- Prescaler:
  - counts 0..DIV-1 while enable=1
  - tick=1 in the cycle where the count equals DIV-1; the count then wraps to 0
  - enable=0 holds the count at 0 and keeps tick at 0
  - re-enabling gives the first tick DIV cycles later
- FSM states: IDLE and GRANT.
  - IDLE: on tick with |req, select the first requester with req set, searching from pointer+1 and wrapping mod N_REQ. The FSM registers grant=onehot(sel), grant_idx=sel, busy=1, and moves to GRANT.
  - IDLE: on tick with no req, the tick is consumed and nothing changes.
  - GRANT: done[grant_idx]=1 clears grant and busy, sets pointer=grant_idx, and returns to IDLE.
  - GRANT: done bits of non-granted requesters are ignored.
  - GRANT: req deassertion by the granted requester is ignored; the grant stays until its done.
- Overrun: a tick in GRANT without same-cycle done[grant_idx] increments overrun_cnt, saturating at 255.
- Simultaneous done[grant_idx] and tick in GRANT:
  - the release takes effect
  - no overrun is counted
  - that tick does not arbitrate; the next grant waits for the following tick
- enable=0 during GRANT: the grant stays until done; no ticks, no overruns.
- Asynchronous reset mid-grant drops grant immediately and restores all reset values.

## Timing
- tick to grant: 1 cycle (grant is registered in the cycle after tick).
- done to grant deassert and busy=0: 1 cycle.
- Minimum spacing between grants: DIV cycles.
- Tick period: exactly DIV clk cycles with no drift; the divide is exact, and CLK_HZ must be an integer multiple of TICK_HZ (elaboration check).
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package sched_pkg:
  - state enum sched_state_t {IDLE, GRANT}
  - function calc_div(clk_hz, tick_hz)
  - localparam for the overrun counter width (8)
- Sub-module tick_gen holds the prescaler. Parameters: DIV. Ports: clk, rst, enable, tick. Width: $clog2(DIV).
- Round-robin search is a combinational function in the top module.

## Test plan
Use CLK_HZ=10, TICK_HZ=1 (DIV=10) and N_REQ=4 unless stated.
- Free run: enable=1, req=0 → tick high at cycles 9, 19, 29 after reset release; grant stays 0; overrun_cnt=0.
- Round-robin: req=4'b1111, each done pulsed 2 cycles after its grant → grant sequence 0001, 0010, 0100, 1000, 0001, each one cycle after a tick.
- Sparse requests: req=4'b1010 → grants alternate idx 1, 3, 1; idx 0 and 2 are never granted.
- Overrun: grant idx 0, done withheld for 35 cycles → overrun_cnt=3 and grant still 0001. Then done → busy=0 next cycle.
- Tick/done collision: done[grant_idx] in the same cycle as tick → overrun_cnt unchanged, no new grant until the next tick 10 cycles later. Also: done on a non-granted index is ignored.
- Reset and enable: rst low mid-GRANT → grant=0 and busy=0 asynchronously, before the next clk edge. Separately, enable low for 7 cycles → no tick; after re-enable the first tick comes 10 cycles later.
